// File: rtl/mfcc_coef_pingpong_buf.sv
// Two-bank ping-pong coefficient frame buffer between the MFCC/DCT producer and the classifier reader.
// Define MFCC_BUF_OUTREG_EN to add an output register stage, which makes the read latency 2 instead of 1.
module mfcc_coef_pingpong_buf #(
  parameter int DATA_WIDTH      = 14,
  parameter int NUM_COEF        = 13,
  parameter int ADDR_WIDTH      = 8,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic                       rd_frame_valid,
  input  logic                       rd_en,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_data_valid,
  input  logic                       rd_release,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);
  localparam int IDX_W     = $clog2(NUM_COEF);
  localparam int MEM_DEPTH = 2 * NUM_COEF;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                       wr_bank_q, wr_bank_d;
  logic                       rd_bank_q, rd_bank_d;
  logic [1:0]                 full_cnt_q, full_cnt_d;
  logic [IDX_W-1:0]           wr_idx_q, wr_idx_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0]      rd_data1_q, rd_data1_d;
  logic                       rd_valid1_q, rd_valid1_d;

  logic              wr_beat, frame_done, rel_fire, rd_fire, rd_in_range;
  logic [MEM_AW-1:0] wr_phys, rd_phys;

  assign wr_ready       = (full_cnt_q != 2'd2);
  assign rd_frame_valid = (full_cnt_q != 2'd0);
  assign frame_cnt      = frame_cnt_q;

  always_comb begin
    wr_beat     = wr_valid & wr_ready;
    frame_done  = wr_beat & (wr_idx_q == LAST_IDX);
    rel_fire    = rd_release & rd_frame_valid;
    rd_fire     = rd_en & rd_frame_valid;
    rd_in_range = (32'(rd_addr) < NUM_COEF);
    wr_phys     = MEM_AW'(32'(wr_idx_q) + (wr_bank_q ? NUM_COEF : 0));
    rd_phys     = MEM_AW'(32'(rd_addr) + (rd_bank_q ? NUM_COEF : 0));

    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_cnt_d  = full_cnt_q;
    frame_cnt_d = frame_cnt_q;
    rd_valid1_d = rd_fire;
    rd_data1_d  = rd_data1_q;

    if (wr_beat) wr_idx_d = frame_done ? '0 : wr_idx_q + IDX_W'(1);
    if (frame_done) begin
      wr_bank_d   = ~wr_bank_q;
      frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
    end
    if (rel_fire) rd_bank_d = ~rd_bank_q;

    // A completion and a release in the same cycle cancel out in the occupancy count.
    case ({frame_done, rel_fire})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase

    if (rd_fire) rd_data1_d = rd_in_range ? mem[rd_phys] : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_beat) mem[wr_phys] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_cnt_q  <= 2'd0;
      wr_idx_q    <= '0;
      frame_cnt_q <= '0;
      rd_data1_q  <= '0;
      rd_valid1_q <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_cnt_q  <= full_cnt_d;
      wr_idx_q    <= wr_idx_d;
      frame_cnt_q <= frame_cnt_d;
      rd_data1_q  <= rd_data1_d;
      rd_valid1_q <= rd_valid1_d;
    end
  end

`ifdef MFCC_BUF_OUTREG_EN
  logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
  logic                  rd_valid2_q, rd_valid2_d;

  // The second stage only captures real responses so rd_data keeps holding between reads.
  always_comb begin
    rd_valid2_d = rd_valid1_q;
    rd_data2_d  = rd_valid1_q ? rd_data1_q : rd_data2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data2_q  <= '0;
      rd_valid2_q <= 1'b0;
    end else begin
      rd_data2_q  <= rd_data2_d;
      rd_valid2_q <= rd_valid2_d;
    end
  end

  assign rd_data       = rd_data2_q;
  assign rd_data_valid = rd_valid2_q;
`else
  assign rd_data       = rd_data1_q;
  assign rd_data_valid = rd_valid1_q;
`endif

endmodule

// File: tb/tb_mfcc_coef_pingpong_buf.sv
// Bench for mfcc_coef_pingpong_buf: vector table, hand-written corner sequences and random traffic against a frame-queue model.
// The frame counter is built 8 bits wide here so that its wrap is reached in a few thousand cycles.
module tb_mfcc_coef_pingpong_buf;
  localparam int DW  = 14;
  localparam int NC  = 13;
  localparam int AW  = 8;
  localparam int FCW = 8;
`ifdef MFCC_BUF_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  wr_data;
  logic           wr_valid, wr_ready, rd_frame_valid, rd_en, rd_data_valid, rd_release;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;
  logic [FCW-1:0] frame_cnt;

  always #5 clk = ~clk;

  mfcc_coef_pingpong_buf #(
    .DATA_WIDTH(DW), .NUM_COEF(NC), .ADDR_WIDTH(AW), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_frame_valid(rd_frame_valid), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .rd_release(rd_release), .frame_cnt(frame_cnt)
  );

  int vecCount = 0;
  int errCount = 0;

  // Reference model: a queue of complete frames, the frame being assembled, and a response delay line.
  typedef logic [NC-1:0][DW-1:0] frame_t;
  typedef struct packed { logic v; logic [DW-1:0] d; } resp_t;
  frame_t        fq[$];
  frame_t        cur;
  int            curN;
  int            framesDone;
  resp_t         pipe[$];
  logic          expV;
  logic [DW-1:0] expD;

  function automatic void modelReset();
    resp_t r;
    r = '0;
    fq.delete();
    pipe.delete();
    for (int i = 0; i < LAT - 1; i++) pipe.push_back(r);
    curN       = 0;
    framesDone = 0;
    expV       = 1'b0;
    expD       = '0;
  endfunction

  function automatic void modelEdge();
    bit    canWrite = (fq.size() < 2);
    bit    avail    = (fq.size() > 0);
    resp_t r;
    r = '0;
    if (rd_en && avail) begin
      r.v = 1'b1;
      if (32'(rd_addr) < NC) r.d = fq[0][rd_addr];
    end
    pipe.push_back(r);
    while (pipe.size() > LAT - 1) begin
      r    = pipe.pop_front();
      expV = r.v;
      if (r.v) expD = r.d;
    end
    if (rd_release && avail) fq.delete(0);
    if (wr_valid && canWrite) begin
      cur[curN] = wr_data;
      curN++;
      if (curN == NC) begin
        fq.push_back(cur);
        curN = 0;
        framesDone++;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("model_wr_ready", 32'(wr_ready), 32'(fq.size() < 2));
    checkOutput("model_rd_frame_valid", 32'(rd_frame_valid), 32'(fq.size() > 0));
    checkOutput("model_rd_data_valid", 32'(rd_data_valid), 32'(expV));
    checkOutput("model_rd_data", 32'(rd_data), 32'(expD));
    checkOutput("model_frame_cnt", 32'(frame_cnt), 32'(framesDone % (1 << FCW)));
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd, input logic re,
                               input logic [AW-1:0] ra, input logic rr);
    wr_valid   = wv;
    wr_data    = wd;
    rd_en      = re;
    rd_addr    = ra;
    rd_release = rr;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkModel();
  endtask

  task automatic readCheck(input string name, input frame_t expF, input logic wv, input logic [DW-1:0] wd);
    for (int i = 0; i < NC + LAT - 1; i++) begin
      if (i < NC) applyStimulus(wv, wd, 1'b1, AW'(i), 1'b0);
      else        applyStimulus(wv, wd, 1'b0, '0, 1'b0);
      if (i >= LAT - 1) begin
        checkOutput({name, "_valid"}, 32'(rd_data_valid), 32'd1);
        checkOutput(name, 32'(rd_data), 32'(expF[i-(LAT-1)]));
      end
    end
  endtask

  typedef struct packed {
    logic           wv;
    logic [DW-1:0]  wd;
    logic           re;
    logic [AW-1:0]  ra;
    logic           rr;
    logic           eReady;
    logic           eFv;
    logic [FCW-1:0] eCnt;
    logic           eRv;
    logic [DW-1:0]  eRd;
  } vec_t;

  localparam int NROWS = 32;
  vec_t tbl[NROWS];

  initial begin
    frame_t fa, fb, f3, fc, fd, fr;

    // Rows 0-12 write frame 0x100.., 13-25 read it back, then out-of-range read, release and ignored requests.
    for (int i = 0; i < NROWS; i++) begin
      tbl[i]        = '0;
      tbl[i].eReady = 1'b1;
      tbl[i].eFv    = 1'b1;
      tbl[i].eCnt   = FCW'(1);
      tbl[i].eRd    = 14'h10C;
    end
    for (int i = 0; i < NC; i++) begin
      tbl[i].wv   = 1'b1;
      tbl[i].wd   = DW'(32'h100 + i);
      tbl[i].eFv  = (i == NC - 1);
      tbl[i].eCnt = FCW'(i == NC - 1);
      tbl[i].eRd  = '0;
      tbl[NC+i].re  = 1'b1;
      tbl[NC+i].ra  = AW'(i);
      tbl[NC+i].eRv = 1'b1;
      tbl[NC+i].eRd = DW'(32'h100 + i);
    end
    tbl[26].re = 1'b1; tbl[26].ra = 8'd13; tbl[26].eRv = 1'b1; tbl[26].eRd = '0;
    tbl[27].re = 1'b1; tbl[27].ra = 8'd12; tbl[27].eRv = 1'b1; tbl[27].eRd = 14'h10C;
    tbl[28].rr = 1'b1; tbl[28].eFv = 1'b0;
    tbl[29].re = 1'b1; tbl[29].eFv = 1'b0;
    tbl[30].rr = 1'b1; tbl[30].eFv = 1'b0;
    tbl[31].eFv = 1'b0;

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("reset_rd_frame_valid", 32'(rd_frame_valid), 32'd0);
    checkOutput("reset_rd_data_valid", 32'(rd_data_valid), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
    checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    modelReset();

    for (int i = 0; i < NROWS; i++) begin
      applyStimulus(tbl[i].wv, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].rr);
      checkOutput("tbl_wr_ready", 32'(wr_ready), 32'(tbl[i].eReady));
      checkOutput("tbl_rd_frame_valid", 32'(rd_frame_valid), 32'(tbl[i].eFv));
      checkOutput("tbl_frame_cnt", 32'(frame_cnt), 32'(tbl[i].eCnt));
      if (i >= LAT - 1) begin
        checkOutput("tbl_rd_data_valid", 32'(rd_data_valid), 32'(tbl[i-(LAT-1)].eRv));
        checkOutput("tbl_rd_data", 32'(rd_data), 32'(tbl[i-(LAT-1)].eRd));
      end
    end

    // Two full frames, stalled writer, release, then the stalled beat lands as frame 3 coefficient 0.
    for (int i = 0; i < NC; i++) begin
      fa[i] = DW'(32'h200 + i);
      fb[i] = DW'(32'h300 + i);
      f3[i] = (i == 0) ? 14'h3FFF : DW'(32'h400 + i);
      fc[i] = DW'(32'h500 + i);
      fd[i] = DW'(32'h600 + i);
      fr[i] = DW'(32'h800 + i);
    end
    for (int i = 0; i < NC; i++) applyStimulus(1'b1, fa[i], 1'b0, '0, 1'b0);
    for (int i = 0; i < NC; i++) applyStimulus(1'b1, fb[i], 1'b0, '0, 1'b0);
    checkOutput("full_wr_ready", 32'(wr_ready), 32'd0);
    repeat (5) begin
      applyStimulus(1'b1, 14'h3FFF, 1'b0, '0, 1'b0);
      checkOutput("stall_wr_ready", 32'(wr_ready), 32'd0);
    end
    readCheck("intact_frame_a", fa, 1'b1, 14'h3FFF);
    applyStimulus(1'b1, 14'h3FFF, 1'b0, '0, 1'b1);
    checkOutput("release_wr_ready", 32'(wr_ready), 32'd1);
    applyStimulus(1'b1, 14'h3FFF, 1'b0, '0, 1'b0);
    for (int i = 1; i < NC; i++) applyStimulus(1'b1, f3[i], 1'b0, '0, 1'b0);
    readCheck("intact_frame_b", fb, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    readCheck("frame3", f3, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

    // Last beat of frame D, a read of frame C and the release of C all in one cycle.
    for (int i = 0; i < NC; i++) applyStimulus(1'b1, fc[i], 1'b0, '0, 1'b0);
    for (int i = 0; i < NC - 1; i++) applyStimulus(1'b1, fd[i], 1'b0, '0, 1'b0);
    applyStimulus(1'b1, fd[NC-1], 1'b1, 8'd5, 1'b1);
    checkOutput("same_cycle_frame_valid", 32'(rd_frame_valid), 32'd1);
    checkOutput("same_cycle_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("same_cycle_frame_cnt", 32'(frame_cnt), 32'd6);
    repeat (LAT - 1) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("same_cycle_old_frame", 32'(rd_data), 32'h505);
    readCheck("frame_d", fd, 1'b0, '0);

    // Reset in the middle of a frame acts immediately and drops the partial frame.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, DW'(32'h700 + i), 1'b0, '0, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("midrst_rd_frame_valid", 32'(rd_frame_valid), 32'd0);
    checkOutput("midrst_rd_data_valid", 32'(rd_data_valid), 32'd0);
    checkOutput("midrst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NC; i++) applyStimulus(1'b1, fr[i], 1'b0, '0, 1'b0);
    checkOutput("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
    readCheck("post_rst_frame", fr, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

    // 2**FCW more frames with immediate release wrap the counter back to 1.
    for (int f = 0; f < (1 << FCW); f++)
      for (int b = 0; b < NC; b++) applyStimulus(1'b1, DW'($urandom), 1'b0, '0, (b == 0));
    checkOutput("wrap_frame_cnt", 32'(frame_cnt), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

    for (int c = 0; c < 3000; c++)
      applyStimulus(($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom),
                    AW'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
